// File: rtl/pwm_scan_controller.sv
// Round-robin PWM pulse-width scanner: one shared counter measures a full
// high pulse on each channel in turn and applies LOW/HIGH hysteresis to
// produce a filtered digital level per channel.
module pwm_scan_controller #(
  parameter int CHANNELS           = 4,
  parameter int CHANNEL_WIDTH      = 2,
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int COUNTER_WIDTH      = 11,
  parameter int HIGH_COUNTER_VALUE = 12,
  parameter int LOW_COUNTER_VALUE  = 11
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic [CHANNELS-1:0]      pwm_i,
  output logic [CHANNELS-1:0]      output_pins_o,
  output logic [COUNTER_WIDTH-1:0] width_o,
  output logic [CHANNEL_WIDTH-1:0] channel_o,
  output logic                     valid_o,
  output logic                     timeout_o,
  output logic                     busy_o
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_CNT  = COUNTER_WIDTH'(MAX_COUNTER_VALUE);
  localparam logic [COUNTER_WIDTH-1:0] HIGH_CNT = COUNTER_WIDTH'(HIGH_COUNTER_VALUE);
  localparam logic [COUNTER_WIDTH-1:0] LOW_CNT  = COUNTER_WIDTH'(LOW_COUNTER_VALUE);
  localparam logic [CHANNEL_WIDTH-1:0] LAST_CH  = CHANNEL_WIDTH'(CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOW  = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    REPORT    = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [CHANNELS-1:0]      sync_p0, sync_p1;
  logic                     sel_s;
  logic [COUNTER_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CHANNEL_WIDTH-1:0] ptr;
  logic                     rpt_go;
  logic [COUNTER_WIDTH-1:0] rpt_width;
  logic                     rpt_timeout;

  // Counter increment that sticks at the timeout value instead of wrapping.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c);
    return (c >= MAX_CNT) ? MAX_CNT : c + 1'b1;
  endfunction

  // Hysteresis decision: only widths outside the LOW..HIGH band move the level.
  function automatic logic hyst(input logic cur, input logic [COUNTER_WIDTH-1:0] w);
    if (w > HIGH_CNT) return 1'b1;
    if (w < LOW_CNT)  return 1'b0;
    return cur;
  endfunction

  // Two-flop synchronizer on every PWM pin; the FSM only sees the selected bit.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pwm_i;
      sync_p1 <= sync_p0;
    end
  end

  assign sel_s   = sync_p1[ptr];
  assign cnt_inc = sat_inc(cnt);

  // FSM state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state, next-count and report payload for the current slot.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rpt_go      = 1'b0;
    rpt_width   = '0;
    rpt_timeout = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable_i) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!enable_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!sel_s) begin
          state_nxt = WAIT_RISE;
          cnt_nxt   = '0;
        end else if (cnt_inc == MAX_CNT) begin
          state_nxt   = REPORT;
          cnt_nxt     = '0;
          rpt_go      = 1'b1;
          rpt_width   = MAX_CNT;
          rpt_timeout = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_RISE: begin
        if (!enable_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (sel_s) begin
          state_nxt = MEASURE;
          cnt_nxt   = COUNTER_WIDTH'(1);
        end else if (cnt_inc == MAX_CNT) begin
          state_nxt   = REPORT;
          cnt_nxt     = '0;
          rpt_go      = 1'b1;
          rpt_width   = '0;
          rpt_timeout = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      MEASURE: begin
        if (!enable_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!sel_s) begin
          state_nxt = REPORT;
          cnt_nxt   = '0;
          rpt_go    = 1'b1;
          rpt_width = cnt;
        end else if (cnt_inc == MAX_CNT) begin
          state_nxt   = REPORT;
          cnt_nxt     = '0;
          rpt_go      = 1'b1;
          rpt_width   = MAX_CNT;
          rpt_timeout = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      REPORT: begin
        cnt_nxt   = '0;
        state_nxt = enable_i ? WAIT_LOW : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    valid_o = (state == REPORT);
    busy_o  = (state != IDLE);
  end

  // Counter, channel pointer and report registers; results land as REPORT is entered.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt           <= '0;
      ptr           <= '0;
      output_pins_o <= '0;
      width_o       <= '0;
      channel_o     <= '0;
      timeout_o     <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (rpt_go) begin
        width_o            <= rpt_width;
        timeout_o          <= rpt_timeout;
        channel_o          <= ptr;
        output_pins_o[ptr] <= hyst(output_pins_o[ptr], rpt_width);
      end
      if (state == REPORT) ptr <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_scan_controller.sv
// Bench for pwm_scan_controller: directed pulse scenarios with random noise
// on the channels that are not being measured.
module tb_pwm_scan_controller;

  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int MAXC  = 2000;
  localparam int CNTW  = 11;
  localparam int HIGHV = 12;
  localparam int LOWV  = 11;

  logic            clock_i  = 1'b0;
  logic            reset_i  = 1'b0;
  logic            enable_i = 1'b0;
  logic [NCH-1:0]  pwm_i    = '0;
  logic [NCH-1:0]  output_pins_o;
  logic [CNTW-1:0] width_o;
  logic [CW-1:0]   channel_o;
  logic            valid_o;
  logic            timeout_o;
  logic            busy_o;

  pwm_scan_controller #(
    .CHANNELS(NCH), .CHANNEL_WIDTH(CW), .MAX_COUNTER_VALUE(MAXC),
    .COUNTER_WIDTH(CNTW), .HIGH_COUNTER_VALUE(HIGHV), .LOW_COUNTER_VALUE(LOWV)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .pwm_i(pwm_i),
    .output_pins_o(output_pins_o), .width_o(width_o), .channel_o(channel_o),
    .valid_o(valid_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  int vectors      = 0;
  int miscompares  = 0;
  int cyc_n        = 0;
  int vld_cnt      = 0;
  int last_vld_cyc = -1000;

  logic [NCH-1:0] ctl_mask = '0, ctl_val = '0, tie_mask = '0, tie_val = '0;

  // reference model state
  int m_ptr   = 0;
  bit m_pins [NCH];
  int m_width = 0;
  int m_chan  = 0;
  int m_to    = 0;

  int hseq [5] = '{5, 20, 11, 12, 10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] pins_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_pins[i];
    return v;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({valid_o, busy_o, timeout_o, output_pins_o, width_o, channel_o});
  endfunction

  task automatic apply();
    logic [NCH-1:0] rnd;
    rnd   = NCH'($urandom);
    pwm_i = (rnd & ~(tie_mask | ctl_mask)) | (tie_val & tie_mask & ~ctl_mask) | (ctl_val & ctl_mask);
  endtask

  task automatic cyc();
    @(posedge clock_i);
    #1;
    cyc_n++;
    if (valid_o === 1'b1) vld_cnt++;
    apply();
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc();
      if (valid_o === 1'b1) got = 1'b1;
    end
    chk("valid_seen", 32'(got), 32'd1);
  endtask

  task automatic check_report(input int exp_w, input int exp_to);
    int gap;
    gap          = cyc_n - last_vld_cyc;
    last_vld_cyc = cyc_n;
    chk("valid_spacing", 32'(gap >= 4), 32'd1);
    chk("channel", 32'(channel_o), 32'(m_ptr));
    chk("width", 32'(width_o), 32'(exp_w));
    chk("timeout", 32'(timeout_o), 32'(exp_to));
    if (exp_w > HIGHV)     m_pins[m_ptr] = 1'b1;
    else if (exp_w < LOWV) m_pins[m_ptr] = 1'b0;
    chk("pins", 32'(output_pins_o), 32'(pins_vec()));
    m_width = exp_w;
    m_chan  = m_ptr;
    m_to    = exp_to;
    m_ptr   = (m_ptr + 1) % NCH;
  endtask

  task automatic do_pulse(input int h);
    int lowlen;
    bit got;
    lowlen   = $urandom_range(2, 8);
    ctl_mask = NCH'(1) << m_ptr;
    ctl_val  = '0;
    apply();
    cyc();
    chk("valid_single_cycle", 32'(valid_o), 32'd0);
    chk("busy_scanning", 32'(busy_o), 32'd1);
    for (int i = 1; i < lowlen; i++) cyc();
    ctl_val = ctl_mask;
    apply();
    for (int i = 0; i < h; i++) cyc();
    ctl_val = '0;
    apply();
    wait_valid(40, got);
    check_report(h, 0);
  endtask

  task automatic do_timeout(input bit lvl);
    bit got;
    int gap;
    ctl_mask = '0;
    ctl_val  = '0;
    apply();
    wait_valid(MAXC + 20, got);
    gap = cyc_n - last_vld_cyc;
    if (lvl) chk("stuck_high_latency", 32'(gap), 32'(MAXC + 1));
    check_report(lvl ? MAXC : 0, 1);
  endtask

  task automatic start_partial();
    ctl_mask = NCH'(1) << m_ptr;
    ctl_val  = '0;
    apply();
    repeat (4) cyc();
    ctl_val = ctl_mask;
    apply();
    repeat (6) cyc();
  endtask

  initial begin
    int vc;
    for (int i = 0; i < NCH; i++) m_pins[i] = 1'b0;

    // reset held with enable low
    reset_i  = 1'b0;
    enable_i = 1'b0;
    apply();
    repeat (3) begin
      cyc();
      chk("reset_outputs", all_outs(), 32'd0);
    end
    reset_i = 1'b1;
    repeat (10) begin
      cyc();
      chk("idle_outputs", all_outs(), 32'd0);
    end

    // basic measurement plus hysteresis walk on channel 1
    enable_i = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < NCH; c++) begin
        if (r == 0 && c == 0) do_pulse(20);
        else if (c == 1)      do_pulse(hseq[r]);
        else                  do_pulse($urandom_range(1, 40));
      end
    end

    // stuck channels: 2 tied high, 3 tied low
    tie_mask = 4'b1100;
    tie_val  = 4'b0100;
    do_pulse($urandom_range(1, 40));
    do_pulse($urandom_range(1, 40));
    do_timeout(1'b1);
    do_timeout(1'b0);
    tie_mask = '0;
    tie_val  = '0;

    // enable dropped mid-measurement on channel 1
    do_pulse($urandom_range(1, 40));
    start_partial();
    vc       = vld_cnt;
    enable_i = 1'b0;
    cyc();
    chk("disable_busy", 32'(busy_o), 32'd0);
    chk("disable_valid", 32'(valid_o), 32'd0);
    repeat (5) cyc();
    chk("disable_no_report", 32'(vld_cnt - vc), 32'd0);
    chk("disable_width_held", 32'(width_o), 32'(m_width));
    chk("disable_channel_held", 32'(channel_o), 32'(m_chan));
    chk("disable_timeout_held", 32'(timeout_o), 32'(m_to));
    chk("disable_pins_held", 32'(output_pins_o), 32'(pins_vec()));
    enable_i = 1'b1;
    do_pulse($urandom_range(1, 40));

    // a few rounds of random widths
    repeat (8) do_pulse($urandom_range(1, 40));

    // reset asserted mid-measurement
    start_partial();
    reset_i = 1'b0;
    #1;
    chk("midscan_reset_outputs", all_outs(), 32'd0);
    cyc();
    cyc();
    m_ptr = 0;
    for (int i = 0; i < NCH; i++) m_pins[i] = 1'b0;
    m_width      = 0;
    m_chan       = 0;
    m_to         = 0;
    last_vld_cyc = -1000;
    ctl_mask     = NCH'(1);
    ctl_val      = '0;
    apply();
    reset_i = 1'b1;
    do_pulse($urandom_range(1, 40));
    do_pulse($urandom_range(13, 40));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
